// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants and FSM encoding for the VGA box scheduler
package vga_pkg;

  localparam int nX       = 10;
  localparam int nY       = 9;
  localparam int COLOR_W  = 9;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [COLOR_W-1:0] COLOR_BLACK = '0;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_GRANT = 2'd2,
    ST_DRAW  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
  parameter int N     = 8,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     pending_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic             valid_o
);

  logic [PTR_W-1:0] idx;

  // Scan from the pointer upwards, wrapping, and take the first pending bit
  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = PTR_W'((int'(ptr_i) + i) % N);
      if (!valid_o && pending_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_box_scheduler.sv
// rtl/vga_box_scheduler.sv - frame clear then round-robin box redraws into one pixel write port
module vga_box_scheduler #(
  parameter int NUM_BOXES = 8,
  parameter int BOX_SIZE  = 32,
  parameter int X_FIRST   = 40,
  parameter int X_PITCH   = 80,
  parameter int Y_CENTER  = 240,
  parameter int SCREEN_W  = vga_pkg::SCREEN_W,
  parameter int SCREEN_H  = vga_pkg::SCREEN_H,
  parameter int nX        = vga_pkg::nX,
  parameter int nY        = vga_pkg::nY,
  parameter int COLOR_W   = vga_pkg::COLOR_W
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic [NUM_BOXES-1:0]         req,
  input  logic [NUM_BOXES*COLOR_W-1:0] req_color,
  output logic [NUM_BOXES-1:0]         gnt,
  output logic                         busy,
  output logic                         clear_done,
  output logic [nX-1:0]                vga_x,
  output logic [nY-1:0]                vga_y,
  output logic [COLOR_W-1:0]           vga_color,
  output logic                         vga_write
);
  import vga_pkg::*;

  localparam int PTR_W = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;
  localparam int CW    = nX + 1;
  localparam logic [CW-1:0]    HALF     = CW'(BOX_SIZE / 2);
  localparam logic [CW-1:0]    Y0       = CW'(Y_CENTER) - HALF;
  localparam logic [CW-1:0]    BOX_LAST = CW'(BOX_SIZE - 1);
  localparam logic [CW-1:0]    W_LAST   = CW'(SCREEN_W - 1);
  localparam logic [CW-1:0]    H_LAST   = CW'(SCREEN_H - 1);
  localparam logic [PTR_W-1:0] IDX_LAST = PTR_W'(NUM_BOXES - 1);

  state_t state_q, state_d;
  logic [NUM_BOXES-1:0]              pend_q, pend_d, gnt_q, gnt_d, arb_gnt;
  logic [NUM_BOXES-1:0][COLOR_W-1:0] color_q, color_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d, sel_q, sel_d, arb_idx;
  logic [COLOR_W-1:0] draw_color_q, draw_color_d, vga_color_q, vga_color_d;
  logic [CW-1:0]      cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d, base_x_q, base_x_d, nx, ny;
  logic [nX-1:0]      vga_x_q, vga_x_d;
  logic [nY-1:0]      vga_y_q, vga_y_d;
  logic               vga_write_q, vga_write_d, busy_q, busy_d, clear_done_q, clear_done_d;
  logic               arb_valid;

  rr_arbiter #(.N(NUM_BOXES), .PTR_W(PTR_W)) u_arb (
    .pending_i (pend_q),
    .ptr_i     (ptr_q),
    .gnt_o     (arb_gnt),
    .valid_o   (arb_valid)
  );

  // Convert the one-hot arbiter pick into a box index
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_BOXES; i++) begin
      if (arb_gnt[i]) arb_idx = PTR_W'(i);
    end
  end

  // State register; reset always restarts the frame clear
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_q <= ST_CLEAR;
    else       state_q <= state_d;
  end

  // Next state: clear ends after its last write is shown, draws end after the last box pixel
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (vga_write_q && cnt_x_q == W_LAST && cnt_y_q == H_LAST) state_d = ST_IDLE;
      ST_IDLE:  if (arb_valid) state_d = ST_GRANT;
      ST_GRANT: state_d = ST_DRAW;
      ST_DRAW:  if (cnt_x_q == BOX_LAST && cnt_y_q == BOX_LAST) state_d = ST_IDLE;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // Datapath and registered outputs; counters always name the pixel currently on the port
  always_comb begin
    pend_d       = pend_q;
    color_d      = color_q;
    ptr_d        = ptr_q;
    sel_d        = sel_q;
    gnt_d        = '0;
    draw_color_d = draw_color_q;
    base_x_d     = base_x_q;
    cnt_x_d      = cnt_x_q;
    cnt_y_d      = cnt_y_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_color_d  = vga_color_q;
    vga_write_d  = 1'b0;
    clear_done_d = clear_done_q;
    busy_d       = (state_d != ST_IDLE);
    nx           = '0;
    ny           = '0;

    // Clearing the granted bit first lets a same-cycle request re-arm it
    if (state_q == ST_GRANT) pend_d[sel_q] = 1'b0;
    pend_d = pend_d | req;
    for (int i = 0; i < NUM_BOXES; i++) begin
      if (req[i]) color_d[i] = req_color[i*COLOR_W +: COLOR_W];
    end

    case (state_q)
      ST_CLEAR: begin
        if (!vga_write_q) begin
          cnt_x_d     = '0;
          cnt_y_d     = '0;
          vga_x_d     = '0;
          vga_y_d     = '0;
          vga_color_d = COLOR_BLACK;
          vga_write_d = 1'b1;
        end else if (cnt_x_q == W_LAST && cnt_y_q == H_LAST) begin
          clear_done_d = 1'b1;
        end else begin
          nx          = (cnt_x_q == W_LAST) ? '0 : cnt_x_q + CW'(1);
          ny          = (cnt_x_q == W_LAST) ? cnt_y_q + CW'(1) : cnt_y_q;
          cnt_x_d     = nx;
          cnt_y_d     = ny;
          vga_x_d     = nX'(nx);
          vga_y_d     = nY'(ny);
          vga_color_d = COLOR_BLACK;
          vga_write_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_d = arb_gnt;
          sel_d = arb_idx;
        end
      end
      ST_GRANT: begin
        draw_color_d = color_q[sel_q];
        ptr_d        = (sel_q == IDX_LAST) ? '0 : sel_q + PTR_W'(1);
        base_x_d     = CW'(X_FIRST) + CW'(sel_q) * CW'(X_PITCH) - HALF;
        cnt_x_d      = '0;
        cnt_y_d      = '0;
        vga_x_d      = nX'(base_x_d);
        vga_y_d      = nY'(Y0);
        vga_color_d  = color_q[sel_q];
        vga_write_d  = 1'b1;
      end
      ST_DRAW: begin
        if (!(cnt_x_q == BOX_LAST && cnt_y_q == BOX_LAST)) begin
          nx          = (cnt_x_q == BOX_LAST) ? '0 : cnt_x_q + CW'(1);
          ny          = (cnt_x_q == BOX_LAST) ? cnt_y_q + CW'(1) : cnt_y_q;
          cnt_x_d     = nx;
          cnt_y_d     = ny;
          vga_x_d     = nX'(base_x_q + nx);
          vga_y_d     = nY'(Y0 + ny);
          vga_color_d = (nx == '0 || nx == BOX_LAST || ny == '0 || ny == BOX_LAST)
                        ? draw_color_q : COLOR_BLACK;
          vga_write_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; async reset drops the write strobe at once
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pend_q       <= '0;
      color_q      <= '0;
      ptr_q        <= '0;
      sel_q        <= '0;
      gnt_q        <= '0;
      draw_color_q <= '0;
      base_x_q     <= '0;
      cnt_x_q      <= '0;
      cnt_y_q      <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_color_q  <= '0;
      vga_write_q  <= 1'b0;
      busy_q       <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      color_q      <= color_d;
      ptr_q        <= ptr_d;
      sel_q        <= sel_d;
      gnt_q        <= gnt_d;
      draw_color_q <= draw_color_d;
      base_x_q     <= base_x_d;
      cnt_x_q      <= cnt_x_d;
      cnt_y_q      <= cnt_y_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_color_q  <= vga_color_d;
      vga_write_q  <= vga_write_d;
      busy_q       <= busy_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign clear_done = clear_done_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_color  = vga_color_q;
  assign vga_write  = vga_write_q;

endmodule
